// File: rtl/ex_mem_pipe_stage_if.sv
// ex_mem_pipe_stage_if
// Bundles the EX-side and MEM-side handshake and payload of the elastic
// EX->MEM pipeline register.
//   EX side : in_valid / in_ready, RegWriteE, MemtoRegE, MemWriteE,
//             ALUInE, WriteDataE, WriteRegE
//   MEM side: out_valid / out_ready, RegWriteM, MemtoRegM, MemWriteM,
//             ALUOutM, WriteDataM, WriteRegM
//   Status  : occupancy (number of valid stages, 0..DEPTH)
// modport slave  : the pipeline stage itself
// modport master : the surrounding core / testbench driving both ends
interface ex_mem_pipe_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int DEPTH  = 1
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic              in_valid;
  logic              in_ready;
  logic              RegWriteE;
  logic              MemtoRegE;
  logic              MemWriteE;
  logic [DATA_W-1:0] ALUInE;
  logic [DATA_W-1:0] WriteDataE;
  logic [REG_W-1:0]  WriteRegE;

  logic              out_valid;
  logic              out_ready;
  logic              RegWriteM;
  logic              MemtoRegM;
  logic              MemWriteM;
  logic [DATA_W-1:0] ALUOutM;
  logic [DATA_W-1:0] WriteDataM;
  logic [REG_W-1:0]  WriteRegM;

  logic [OCC_W-1:0]  occupancy;

  modport slave (
    input  in_valid, RegWriteE, MemtoRegE, MemWriteE, ALUInE, WriteDataE, WriteRegE,
    input  out_ready,
    output in_ready,
    output out_valid, RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM,
    output occupancy
  );

  modport master (
    output in_valid, RegWriteE, MemtoRegE, MemWriteE, ALUInE, WriteDataE, WriteRegE,
    output out_ready,
    input  in_ready,
    input  out_valid, RegWriteM, MemtoRegM, MemWriteM, ALUOutM, WriteDataM, WriteRegM,
    input  occupancy
  );
endinterface

// File: rtl/ex_mem_pipe_stage.sv
// ex_mem_pipe_stage
// Elastic EX->MEM pipeline register with DEPTH stages (1..8), valid/ready
// handshake, backpressure, flush and occupancy reporting.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset, clears all stages
//   flush - synchronous kill of every in-flight entry (data fields hold)
//   bus   - slave modport of ex_mem_pipe_stage_if (EX inputs, MEM outputs,
//           occupancy)
// Stage 0 receives from EX, stage DEPTH-1 drives the MEM outputs.
module ex_mem_pipe_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int DEPTH  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  ex_mem_pipe_stage_if.slave     bus
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]  stage_valid;
  logic [DEPTH-1:0]  stage_reg_write;
  logic [DEPTH-1:0]  stage_mem_to_reg;
  logic [DEPTH-1:0]  stage_mem_write;
  logic [DATA_W-1:0] stage_alu   [DEPTH];
  logic [DATA_W-1:0] stage_wdata [DEPTH];
  logic [REG_W-1:0]  stage_wreg  [DEPTH];

  logic [DEPTH-1:0]  can_load;
  logic              accept;

  logic [DEPTH-1:0]  src_valid;
  logic [DEPTH-1:0]  src_reg_write;
  logic [DEPTH-1:0]  src_mem_to_reg;
  logic [DEPTH-1:0]  src_mem_write;
  logic [DATA_W-1:0] src_alu   [DEPTH];
  logic [DATA_W-1:0] src_wdata [DEPTH];
  logic [REG_W-1:0]  src_wreg  [DEPTH];

  logic [OCC_W-1:0]  occ;

  // Ready chain, walked from the output back to the input. A stage can load
  // when it is empty or its contents move on, so bubbles collapse even while
  // MEM is stalled. Purely combinational: no skid buffer.
  always_comb begin
    logic chain;
    chain    = bus.out_ready;
    can_load = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      chain       = !stage_valid[k] || chain;
      can_load[k] = chain;
    end
  end

  assign accept       = can_load[0] && !flush;
  assign bus.in_ready = accept;

  // Source of each stage: EX inputs for stage 0, previous stage otherwise.
  always_comb begin
    src_valid      = '0;
    src_reg_write  = '0;
    src_mem_to_reg = '0;
    src_mem_write  = '0;
    src_alu        = '{default: '0};
    src_wdata      = '{default: '0};
    src_wreg       = '{default: '0};

    src_valid[0]      = bus.in_valid && accept;
    src_reg_write[0]  = bus.RegWriteE;
    src_mem_to_reg[0] = bus.MemtoRegE;
    src_mem_write[0]  = bus.MemWriteE;
    src_alu[0]        = bus.ALUInE;
    src_wdata[0]      = bus.WriteDataE;
    src_wreg[0]       = bus.WriteRegE;

    for (int k = 1; k < DEPTH; k++) begin
      src_valid[k]      = stage_valid[k-1];
      src_reg_write[k]  = stage_reg_write[k-1];
      src_mem_to_reg[k] = stage_mem_to_reg[k-1];
      src_mem_write[k]  = stage_mem_write[k-1];
      src_alu[k]        = stage_alu[k-1];
      src_wdata[k]      = stage_wdata[k-1];
      src_wreg[k]       = stage_wreg[k-1];
    end
  end

  // Stage registers. Control bits are qualified by the source valid so an
  // empty slot never carries a live write enable; data fields follow the
  // source regardless. Flush clears valid and control but keeps data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid      <= '0;
      stage_reg_write  <= '0;
      stage_mem_to_reg <= '0;
      stage_mem_write  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        stage_alu[k]   <= '0;
        stage_wdata[k] <= '0;
        stage_wreg[k]  <= '0;
      end
    end else if (flush) begin
      stage_valid      <= '0;
      stage_reg_write  <= '0;
      stage_mem_to_reg <= '0;
      stage_mem_write  <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (can_load[k]) begin
          stage_valid[k]      <= src_valid[k];
          stage_reg_write[k]  <= src_valid[k] && src_reg_write[k];
          stage_mem_to_reg[k] <= src_valid[k] && src_mem_to_reg[k];
          stage_mem_write[k]  <= src_valid[k] && src_mem_write[k];
          stage_alu[k]        <= src_alu[k];
          stage_wdata[k]      <= src_wdata[k];
          stage_wreg[k]       <= src_wreg[k];
        end
      end
    end
  end

  // Occupancy is a popcount of the registered valid bits.
  always_comb begin
    occ = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ = occ + OCC_W'(stage_valid[k]);
    end
  end

  assign bus.occupancy = occ;

  // Control outputs are gated by out_valid so a consumer ignoring the
  // handshake can never act on a bubble; data outputs are shown as stored.
  assign bus.out_valid  = stage_valid[DEPTH-1];
  assign bus.RegWriteM  = stage_reg_write[DEPTH-1]  && stage_valid[DEPTH-1];
  assign bus.MemtoRegM  = stage_mem_to_reg[DEPTH-1] && stage_valid[DEPTH-1];
  assign bus.MemWriteM  = stage_mem_write[DEPTH-1]  && stage_valid[DEPTH-1];
  assign bus.ALUOutM    = stage_alu[DEPTH-1];
  assign bus.WriteDataM = stage_wdata[DEPTH-1];
  assign bus.WriteRegM  = stage_wreg[DEPTH-1];

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// tb_ex_mem_pipe_stage
// Directed bench for ex_mem_pipe_stage at DEPTH = 3, 2 and 1, each instance
// with its own interface and flush, sharing clk and rst.
module tb_ex_mem_pipe_stage;
  logic clk;
  logic rst;
  logic f3;
  logic f2;
  logic f1;

  int total;
  int bad;

  ex_mem_pipe_stage_if #(.DATA_W(32), .REG_W(5), .DEPTH(3)) b3 ();
  ex_mem_pipe_stage_if #(.DATA_W(32), .REG_W(5), .DEPTH(2)) b2 ();
  ex_mem_pipe_stage_if #(.DATA_W(32), .REG_W(5), .DEPTH(1)) b1 ();

  ex_mem_pipe_stage #(.DATA_W(32), .REG_W(5), .DEPTH(3)) u3 (
    .clk(clk), .rst(rst), .flush(f3), .bus(b3.slave));
  ex_mem_pipe_stage #(.DATA_W(32), .REG_W(5), .DEPTH(2)) u2 (
    .clk(clk), .rst(rst), .flush(f2), .bus(b2.slave));
  ex_mem_pipe_stage #(.DATA_W(32), .REG_W(5), .DEPTH(1)) u1 (
    .clk(clk), .rst(rst), .flush(f1), .bus(b1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    f3 = 1'b0; f2 = 1'b0; f1 = 1'b0;
    b3.in_valid = 1'b0; b3.RegWriteE = 1'b0; b3.MemtoRegE = 1'b0; b3.MemWriteE = 1'b0;
    b3.ALUInE = '0; b3.WriteDataE = '0; b3.WriteRegE = '0; b3.out_ready = 1'b0;
    b2.in_valid = 1'b0; b2.RegWriteE = 1'b0; b2.MemtoRegE = 1'b0; b2.MemWriteE = 1'b0;
    b2.ALUInE = '0; b2.WriteDataE = '0; b2.WriteRegE = '0; b2.out_ready = 1'b0;
    b1.in_valid = 1'b0; b1.RegWriteE = 1'b0; b1.MemtoRegE = 1'b0; b1.MemWriteE = 1'b0;
    b1.ALUInE = '0; b1.WriteDataE = '0; b1.WriteRegE = '0; b1.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;

    // Reset state
    checkOutput("rst_out_valid", 32'(b3.out_valid), 32'h0);
    checkOutput("rst_occ", 32'(b3.occupancy), 32'h0);
    checkOutput("rst_in_ready", 32'(b3.in_ready), 32'h1);
    checkOutput("rst_alu", b3.ALUOutM, 32'h0);
    checkOutput("rst_regwrite", 32'(b3.RegWriteM), 32'h0);
    checkOutput("rst_d2_out_valid", 32'(b2.out_valid), 32'h0);

    // Test 1: DEPTH=3 latency, single entry
    b3.out_ready = 1'b1;
    b3.in_valid = 1'b1; b3.ALUInE = 32'h11; b3.WriteRegE = 5'd5; b3.RegWriteE = 1'b1;
    tick();
    b3.in_valid = 1'b0; b3.ALUInE = 32'h0; b3.WriteRegE = 5'd0; b3.RegWriteE = 1'b0;
    checkOutput("t1_c1_valid", 32'(b3.out_valid), 32'h0);
    checkOutput("t1_c1_occ", 32'(b3.occupancy), 32'h1);
    tick();
    checkOutput("t1_c2_valid", 32'(b3.out_valid), 32'h0);
    checkOutput("t1_c2_occ", 32'(b3.occupancy), 32'h1);
    tick();
    checkOutput("t1_c3_valid", 32'(b3.out_valid), 32'h1);
    checkOutput("t1_c3_alu", b3.ALUOutM, 32'h11);
    checkOutput("t1_c3_wreg", 32'(b3.WriteRegM), 32'h5);
    checkOutput("t1_c3_regwrite", 32'(b3.RegWriteM), 32'h1);
    checkOutput("t1_c3_occ", 32'(b3.occupancy), 32'h1);
    tick();
    checkOutput("t1_c4_valid", 32'(b3.out_valid), 32'h0);
    checkOutput("t1_c4_regwrite", 32'(b3.RegWriteM), 32'h0);
    checkOutput("t1_c4_occ", 32'(b3.occupancy), 32'h0);

    // Test 2: DEPTH=2 backpressure then in-order drain
    b2.out_ready = 1'b0;
    b2.in_valid = 1'b1; b2.RegWriteE = 1'b1; b2.ALUInE = 32'hA;
    #1 checkOutput("t2_rdy_a", 32'(b2.in_ready), 32'h1);
    tick();
    b2.ALUInE = 32'hB;
    #1 checkOutput("t2_rdy_b", 32'(b2.in_ready), 32'h1);
    tick();
    b2.ALUInE = 32'hC;
    #1;
    checkOutput("t2_rdy_c", 32'(b2.in_ready), 32'h0);
    checkOutput("t2_full_occ", 32'(b2.occupancy), 32'h2);
    checkOutput("t2_full_alu", b2.ALUOutM, 32'hA);
    tick();
    checkOutput("t2_hold_alu", b2.ALUOutM, 32'hA);
    checkOutput("t2_hold_occ", 32'(b2.occupancy), 32'h2);
    checkOutput("t2_hold_valid", 32'(b2.out_valid), 32'h1);
    b2.out_ready = 1'b1;
    #1 checkOutput("t2_rdy_release", 32'(b2.in_ready), 32'h1);
    tick();
    b2.in_valid = 1'b0; b2.RegWriteE = 1'b0;
    checkOutput("t2_drain_b", b2.ALUOutM, 32'hB);
    checkOutput("t2_drain_b_valid", 32'(b2.out_valid), 32'h1);
    tick();
    checkOutput("t2_drain_c", b2.ALUOutM, 32'hC);
    checkOutput("t2_drain_c_valid", 32'(b2.out_valid), 32'h1);
    checkOutput("t2_drain_c_occ", 32'(b2.occupancy), 32'h1);
    tick();
    checkOutput("t2_empty_valid", 32'(b2.out_valid), 32'h0);
    checkOutput("t2_empty_occ", 32'(b2.occupancy), 32'h0);

    // Test 3: DEPTH=3 bubble collapse under out_ready=0
    b3.out_ready = 1'b0;
    b3.in_valid = 1'b1; b3.ALUInE = 32'h77;
    tick();
    b3.in_valid = 1'b0; b3.ALUInE = 32'h0;
    tick();
    tick();
    checkOutput("t3_head_valid", 32'(b3.out_valid), 32'h1);
    checkOutput("t3_head_alu", b3.ALUOutM, 32'h77);
    checkOutput("t3_head_occ", 32'(b3.occupancy), 32'h1);
    b3.in_valid = 1'b1; b3.ALUInE = 32'hD;
    #1 checkOutput("t3_rdy_d1", 32'(b3.in_ready), 32'h1);
    tick();
    checkOutput("t3_occ2", 32'(b3.occupancy), 32'h2);
    checkOutput("t3_rdy_d2", 32'(b3.in_ready), 32'h1);
    tick();
    b3.in_valid = 1'b0; b3.ALUInE = 32'h0;
    checkOutput("t3_occ3", 32'(b3.occupancy), 32'h3);
    checkOutput("t3_rdy_full", 32'(b3.in_ready), 32'h0);
    checkOutput("t3_head_hold", b3.ALUOutM, 32'h77);

    // Test 4: DEPTH=2 flush with simultaneous in_valid and out_ready
    b2.out_ready = 1'b0;
    b2.in_valid = 1'b1; b2.MemWriteE = 1'b1; b2.WriteDataE = 32'h99; b2.WriteRegE = 5'd3;
    b2.ALUInE = 32'h21;
    tick();
    b2.ALUInE = 32'h22;
    tick();
    checkOutput("t4_full_memwrite", 32'(b2.MemWriteM), 32'h1);
    checkOutput("t4_full_occ", 32'(b2.occupancy), 32'h2);
    checkOutput("t4_full_alu", b2.ALUOutM, 32'h21);
    f2 = 1'b1; b2.in_valid = 1'b1; b2.ALUInE = 32'h55; b2.out_ready = 1'b1;
    #1 checkOutput("t4_flush_rdy", 32'(b2.in_ready), 32'h0);
    tick();
    f2 = 1'b0; b2.in_valid = 1'b0; b2.MemWriteE = 1'b0;
    checkOutput("t4_post_valid", 32'(b2.out_valid), 32'h0);
    checkOutput("t4_post_memwrite", 32'(b2.MemWriteM), 32'h0);
    checkOutput("t4_post_occ", 32'(b2.occupancy), 32'h0);
    checkOutput("t4_post_alu", b2.ALUOutM, 32'h21);
    checkOutput("t4_post_wdata", b2.WriteDataM, 32'h99);
    tick();
    checkOutput("t4_nocapture_valid", 32'(b2.out_valid), 32'h0);
    checkOutput("t4_nocapture_occ", 32'(b2.occupancy), 32'h0);

    // Test 6: DEPTH=1 acts as a plain register at full rate
    b1.out_ready = 1'b1; b1.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b1.ALUInE = 32'h100 + 32'(i);
      #1 checkOutput("t6_rdy", 32'(b1.in_ready), 32'h1);
      tick();
      checkOutput("t6_alu", b1.ALUOutM, 32'h100 + 32'(i));
      checkOutput("t6_valid", 32'(b1.out_valid), 32'h1);
    end
    b1.in_valid = 1'b0;
    tick();
    checkOutput("t6_idle_valid", 32'(b1.out_valid), 32'h0);

    // Test 5: asynchronous reset on the full DEPTH=3 instance, between edges
    checkOutput("t5_pre_occ", 32'(b3.occupancy), 32'h3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("t5_async_valid", 32'(b3.out_valid), 32'h0);
    checkOutput("t5_async_alu", b3.ALUOutM, 32'h0);
    checkOutput("t5_async_occ", 32'(b3.occupancy), 32'h0);
    checkOutput("t5_async_rdy", 32'(b3.in_ready), 32'h1);
    #1 rst = 1'b0;
    b3.out_ready = 1'b1;
    b3.in_valid = 1'b1; b3.ALUInE = 32'hE5; b3.WriteRegE = 5'd7; b3.RegWriteE = 1'b1;
    tick();
    b3.in_valid = 1'b0; b3.ALUInE = 32'h0; b3.WriteRegE = 5'd0; b3.RegWriteE = 1'b0;
    tick();
    checkOutput("t5_lat2_valid", 32'(b3.out_valid), 32'h0);
    tick();
    checkOutput("t5_lat3_valid", 32'(b3.out_valid), 32'h1);
    checkOutput("t5_lat3_alu", b3.ALUOutM, 32'hE5);
    checkOutput("t5_lat3_wreg", 32'(b3.WriteRegM), 32'h7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
